cordic_top: RTL and testbench

Pipelined hyperbolic CORDIC in rotation mode. It computes sinh, cosh or exp of a signed Q16.16 argument and sits as a function evaluator in the datapath. The pipeline has one `cordic_unit` per iteration and accepts a new operand every clock. The function is selected at elaboration time.

---
 rtl/cordic_pkg.sv | 54 +++++
 rtl/cordic_unit.sv | 65 ++++++
 rtl/cordic_top.sv | 85 ++++++++
 tb/tb_cordic_top.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and helpers for the hyperbolic CORDIC pipeline.
//   Q_W / Q_FRAC   : signed Q16.16 datapath format
//   SW_*           : function-select encodings (sinh, cosh, exp)
//   stage_shift()  : stage index -> shift amount, with the 4 and 13 repeats
//   atanh_q()      : round(atanh(2^-s) * 65536) for s = 1..31
package cordic_pkg;

  localparam int Q_W    = 32;
  localparam int Q_FRAC = 16;

  localparam int SW_SINH = 1;
  localparam int SW_COSH = 2;
  localparam int SW_EXP  = 3;

  // Hyperbolic CORDIC only converges if shifts 4 and 13 are executed twice.
  function automatic int stage_shift(input int k);
    int s;
    if (k <= 4) begin
      s = k;
    end else if (k <= 14) begin
      s = k - 1;
    end else begin
      s = k - 2;
    end
    return s;
  endfunction

  // Beyond s=17 the rounded angle is zero.
  function automatic logic signed [Q_W-1:0] atanh_q(input int s);
    logic signed [Q_W-1:0] v;
    case (s)
      1:       v = 32'sd36000;
      2:       v = 32'sd16739;
      3:       v = 32'sd8235;
      4:       v = 32'sd4101;
      5:       v = 32'sd2049;
      6:       v = 32'sd1024;
      7:       v = 32'sd512;
      8:       v = 32'sd256;
      9:       v = 32'sd128;
      10:      v = 32'sd64;
      11:      v = 32'sd32;
      12:      v = 32'sd16;
      13:      v = 32'sd8;
      14:      v = 32'sd4;
      15:      v = 32'sd2;
      16:      v = 32'sd1;
      17:      v = 32'sd1;
      default: v = 32'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_unit.sv
// cordic_unit: one registered hyperbolic micro-rotation.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_x/i_y/i_z    : stage inputs (signed Q16.16)
//   o_x/o_y/o_z    : registered stage outputs
//   SHIFT, ATANH   : shift amount and matching angle constant for this stage
module cordic_unit
  import cordic_pkg::*;
#(
  parameter int                    SHIFT = 1,
  parameter logic signed [Q_W-1:0] ATANH = 32'sd36000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic signed [Q_W-1:0] i_x,
  input  logic signed [Q_W-1:0] i_y,
  input  logic signed [Q_W-1:0] i_z,
  output logic signed [Q_W-1:0] o_x,
  output logic signed [Q_W-1:0] o_y,
  output logic signed [Q_W-1:0] o_z
);

  logic                  w_d_pos;
  logic signed [Q_W-1:0] w_x_sh;
  logic signed [Q_W-1:0] w_y_sh;
  logic signed [Q_W-1:0] w_x_nxt;
  logic signed [Q_W-1:0] w_y_nxt;
  logic signed [Q_W-1:0] w_z_nxt;
  logic signed [Q_W-1:0] r_x;
  logic signed [Q_W-1:0] r_y;
  logic signed [Q_W-1:0] r_z;

  // Rotate toward z = 0; z == 0 counts as positive.
  always_comb begin
    w_d_pos = ~i_z[Q_W-1];
    w_x_sh  = i_x >>> SHIFT;
    w_y_sh  = i_y >>> SHIFT;
    if (w_d_pos) begin
      w_x_nxt = i_x + w_y_sh;
      w_y_nxt = i_y + w_x_sh;
      w_z_nxt = i_z - ATANH;
    end else begin
      w_x_nxt = i_x - w_y_sh;
      w_y_nxt = i_y - w_x_sh;
      w_z_nxt = i_z + ATANH;
    end
  end

  // Stage register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= 32'sd0;
      r_y <= 32'sd0;
      r_z <= 32'sd0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      r_z <= w_z_nxt;
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;
  assign o_z = r_z;

endmodule

// File: rtl/cordic_top.sv
// cordic_top: fully pipelined hyperbolic CORDIC (rotation mode), sinh/cosh/exp.
//   CLK        : clock, rising edge
//   RSTN       : async active-low reset, clears every pipeline register and Res
//   ix, iy, iz : signed Q16.16 operands (ix normally 1/K_h, iy normally 0)
//   Res        : signed Q16.16 result, ITERS+2 edges after the operands
//   ITERS      : number of micro-rotation stages; SW: 1 sinh, 2 cosh, else exp
module cordic_top
  import cordic_pkg::*;
#(
  parameter int ITERS = 16,
  parameter int SW    = 3
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic signed [Q_W-1:0] ix,
  input  logic signed [Q_W-1:0] iy,
  input  logic signed [Q_W-1:0] iz,
  output logic signed [Q_W-1:0] Res
);

  // Out-of-range selects fall back to exp.
  localparam int SEL = ((SW == SW_SINH) || (SW == SW_COSH)) ? SW : SW_EXP;

  logic signed [Q_W-1:0] r_x0;
  logic signed [Q_W-1:0] r_y0;
  logic signed [Q_W-1:0] r_z0;
  logic signed [Q_W-1:0] w_x [0:ITERS];
  logic signed [Q_W-1:0] w_y [0:ITERS];
  logic signed [Q_W-1:0] w_z [0:ITERS];
  logic signed [Q_W-1:0] w_res;

  // Input register (stage 0).
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_x0 <= 32'sd0;
      r_y0 <= 32'sd0;
      r_z0 <= 32'sd0;
    end else begin
      r_x0 <= ix;
      r_y0 <= iy;
      r_z0 <= iz;
    end
  end

  assign w_x[0] = r_x0;
  assign w_y[0] = r_y0;
  assign w_z[0] = r_z0;

  for (genvar k = 1; k <= ITERS; k++) begin : g_stage
    localparam int SH = stage_shift(k);
    cordic_unit #(
      .SHIFT (SH),
      .ATANH (atanh_q(SH))
    ) u_unit (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_x     (w_x[k-1]),
      .i_y     (w_y[k-1]),
      .i_z     (w_z[k-1]),
      .o_x     (w_x[k]),
      .o_y     (w_y[k]),
      .o_z     (w_z[k])
    );
  end

  // exp = cosh + sinh, so the exp path just adds the two final coordinates.
  always_comb begin
    w_res = 32'sd0;
    case (SEL)
      SW_SINH: w_res = w_y[ITERS];
      SW_COSH: w_res = w_x[ITERS];
      default: w_res = w_x[ITERS] + w_y[ITERS];
    endcase
  end

  // Output register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      Res <= 32'sd0;
    end else begin
      Res <= w_res;
    end
  end

endmodule

// File: tb/tb_cordic_top.sv
// Directed bench for cordic_top: one instance per function select plus an
// out-of-range select, all sharing the same clock, reset and operands.
module tb_cordic_top;

  localparam int ITERS = 16;
  localparam int LAT   = ITERS + 2;

  localparam logic signed [31:0] IX_NORM = 32'sh0001_3484;
  localparam logic signed [31:0] Z_N10   = 32'shFFFF_0000;
  localparam logic signed [31:0] Z_N06   = 32'shFFFF_6666;
  localparam logic signed [31:0] Z_N02   = 32'shFFFF_CCCD;
  localparam logic signed [31:0] Z_P02   = 32'sh0000_3333;
  localparam logic signed [31:0] Z_P06   = 32'sh0000_999A;
  localparam logic signed [31:0] Z_P10   = 32'sh0001_0000;

  // Expected S*f(z) in LSBs, S = ix*K = 0.99804.
  localparam int E_EXP_N10  = 24062;
  localparam int E_EXP_N06  = 35896;
  localparam int E_EXP_N02  = 53551;
  localparam int E_EXP_P02  = 79889;
  localparam int E_EXP_P06  = 119181;
  localparam int E_EXP_P10  = 177796;
  localparam int E_SCALE    = 65408;
  localparam int E_SINH_P10 = 76867;
  localparam int E_COSH_06  = 77538;
  localparam int E_COSH_10  = 100929;

  logic CLK = 1'b0;
  logic RSTN;
  logic signed [31:0] ix;
  logic signed [31:0] iy;
  logic signed [31:0] iz;
  logic signed [31:0] res_sinh;
  logic signed [31:0] res_cosh;
  logic signed [31:0] res_exp;
  logic signed [31:0] res_dflt;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  cordic_top #(.ITERS(ITERS), .SW(1)) u_sinh (
    .CLK(CLK), .RSTN(RSTN), .ix(ix), .iy(iy), .iz(iz), .Res(res_sinh));
  cordic_top #(.ITERS(ITERS), .SW(2)) u_cosh (
    .CLK(CLK), .RSTN(RSTN), .ix(ix), .iy(iy), .iz(iz), .Res(res_cosh));
  cordic_top #(.ITERS(ITERS), .SW(3)) u_exp (
    .CLK(CLK), .RSTN(RSTN), .ix(ix), .iy(iy), .iz(iz), .Res(res_exp));
  cordic_top #(.ITERS(ITERS), .SW(0)) u_dflt (
    .CLK(CLK), .RSTN(RSTN), .ix(ix), .iy(iy), .iz(iz), .Res(res_dflt));

  // Tolerance: 2^-10 relative plus a small floor for truncation near zero.
  function automatic int tol_of(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a >>> 10) + 32;
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp_v, input int tol);
    int diff;
    checks++;
    diff = obs - exp_v;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp_v, tol);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic flush(input logic signed [31:0] z);
    iz = z;
    repeat (LAT) tick();
  endtask

  logic signed [31:0] seq_z [7];
  int                 seq_e [7];

  initial begin
    seq_z = '{Z_N10, Z_N06, Z_N02, Z_P02, Z_P06, Z_P10, 32'sd0};
    seq_e = '{E_EXP_N10, E_EXP_N06, E_EXP_N02, E_EXP_P02, E_EXP_P06, E_EXP_P10, E_SCALE};

    RSTN = 1'b0;
    ix   = IX_NORM;
    iy   = 32'sd0;
    iz   = 32'sd0;
    repeat (2) tick();
    check_val("reset_exp", res_exp, 0, 0);
    check_val("reset_sinh", res_sinh, 0, 0);
    RSTN = 1'b1;

    // Single operands, all selects.
    flush(Z_N10);
    check_val("exp_n1", res_exp, E_EXP_N10, tol_of(E_EXP_N10));
    check_val("dflt_n1", res_dflt, E_EXP_N10, tol_of(E_EXP_N10));
    check_val("sinh_n1", res_sinh, -E_SINH_P10, tol_of(E_SINH_P10));
    check_val("cosh_n1", res_cosh, E_COSH_10, tol_of(E_COSH_10));
    flush(Z_P10);
    check_val("exp_p1", res_exp, E_EXP_P10, tol_of(E_EXP_P10));
    check_val("dflt_p1", res_dflt, E_EXP_P10, tol_of(E_EXP_P10));
    check_val("sinh_p1", res_sinh, E_SINH_P10, tol_of(E_SINH_P10));
    check_val("cosh_p1", res_cosh, E_COSH_10, tol_of(E_COSH_10));
    flush(32'sd0);
    check_val("sinh_0", res_sinh, 0, tol_of(0));
    check_val("cosh_0", res_cosh, E_SCALE, tol_of(E_SCALE));
    check_val("exp_0", res_exp, E_SCALE, tol_of(E_SCALE));
    flush(Z_P06);
    check_val("cosh_p06", res_cosh, E_COSH_06, tol_of(E_COSH_06));
    flush(Z_N06);
    check_val("cosh_n06", res_cosh, E_COSH_06, tol_of(E_COSH_06));

    // Back-to-back stream: results on consecutive cycles from edge LAT.
    flush(32'sd0);
    for (int c = 1; c <= LAT + 6; c++) begin
      iz = (c <= 7) ? seq_z[c-1] : 32'sd0;
      tick();
      if (c == LAT - 1) check_val("stream_pre", res_exp, E_SCALE, tol_of(E_SCALE));
      if (c >= LAT) check_val($sformatf("stream_%0d", c - LAT), res_exp,
                              seq_e[c-LAT], tol_of(seq_e[c-LAT]));
    end

    // Single pulse: exactly one cycle of the pulse result at edge LAT.
    flush(32'sd0);
    for (int c = 1; c <= LAT + 1; c++) begin
      iz = (c == 1) ? Z_P02 : 32'sd0;
      tick();
      if (c >= LAT - 1) begin
        if (c == LAT) check_val("pulse_hit", res_exp, E_EXP_P02, tol_of(E_EXP_P02));
        else          check_val($sformatf("pulse_edge%0d", c), res_exp, E_SCALE, tol_of(E_SCALE));
      end
    end

    // Asynchronous reset mid-stream.
    flush(32'sd0);
    check_val("pre_rst", res_exp, E_SCALE, tol_of(E_SCALE));
    for (int c = 0; c < 5; c++) begin
      iz = $signed($urandom_range(32'h0001_0000, 0)) - 32'sh0000_8000;
      tick();
    end
    #2;
    RSTN = 1'b0;
    #1;
    check_val("async_exp", res_exp, 0, 0);
    check_val("async_sinh", res_sinh, 0, 0);
    check_val("async_cosh", res_cosh, 0, 0);
    check_val("async_dflt", res_dflt, 0, 0);
    for (int c = 0; c < 4; c++) begin
      ix = $signed($urandom);
      iy = $signed($urandom);
      iz = $signed($urandom);
      tick();
      check_val($sformatf("held_rst_%0d", c), res_exp, 0, 0);
    end

    // Release: zeros for ITERS+1 cycles, then the first post-reset result.
    RSTN = 1'b1;
    ix   = IX_NORM;
    iy   = 32'sd0;
    iz   = Z_P02;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (c < LAT) check_val($sformatf("post_rst_%0d", c), res_exp, 0, 0);
      else         check_val("post_rst_first", res_exp, E_EXP_P02, tol_of(E_EXP_P02));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
